// File: rtl/hazard_stall_ctrl.sv
// Hazard/stall control for a 5-stage MIPS-style pipeline with a multi-cycle mult/div unit.
// Latency: stall/IDEX_clr/md_busy are combinational from the D-stage inputs; scoreboard updates one cycle later.
// Backpressure: stall holds PC and IF/ID and bubbles ID/EX; md_busy blocks HI/LO users until the unit drains.
module hazard_stall_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [1:0] TuseRs,
  input  logic [1:0] TuseRt,
  input  logic [1:0] ResD,
  input  logic [4:0] dstD,
  input  logic       mdD,
  input  logic [1:0] mdstartD,
  input  logic       flushE,
  output logic       stall,
  output logic       IDEX_clr,
  output logic       md_busy
);

  localparam logic [1:0] RES_NW  = 2'b00;
  localparam logic [1:0] RES_ALU = 2'b01;
  localparam logic [1:0] RES_DM  = 2'b10;

  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  // Stage index: 0 = E, 1 = M, 2 = W
  function automatic logic [1:0] tnew_f(input logic [1:0] res, input logic [1:0] stage);
    logic [1:0] t;
    t = 2'd0;
    if (res == RES_ALU && stage == 2'd0) t = 2'd1;
    if (res == RES_DM) begin
      if (stage == 2'd0) t = 2'd2;
      else if (stage == 2'd1) t = 2'd1;
    end
    return t;
  endfunction

  // Tuse of 3 can never be exceeded since Tnew tops out at 2.
  function automatic logic src_haz_f(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [1:0] res, input logic [4:0] dst,
                                     input logic [1:0] stage);
    return (src != 5'd0) && (src == dst) && (res != RES_NW) && (tnew_f(res, stage) > tuse);
  endfunction

  logic [1:0] res_e_q, res_m_q, res_w_q;
  logic [4:0] dst_e_q, dst_m_q, dst_w_q;
  logic       mds_e_q;
  logic [3:0] md_cnt_q;

  logic [1:0] res_e_d;
  logic [4:0] dst_e_d;
  logic       mds_e_d;
  logic [3:0] md_cnt_d;

  logic rs_haz, rt_haz, md_haz, bubble, md_go;

  // Hazard detection against the E/M/W scoreboard and the mult/div unit
  always_comb begin
    rs_haz = src_haz_f(rsD, TuseRs, res_e_q, dst_e_q, 2'd0)
           | src_haz_f(rsD, TuseRs, res_m_q, dst_m_q, 2'd1)
           | src_haz_f(rsD, TuseRs, res_w_q, dst_w_q, 2'd2);
    rt_haz = src_haz_f(rtD, TuseRt, res_e_q, dst_e_q, 2'd0)
           | src_haz_f(rtD, TuseRt, res_m_q, dst_m_q, 2'd1)
           | src_haz_f(rtD, TuseRt, res_w_q, dst_w_q, 2'd2);
    md_busy  = (md_cnt_q != 4'd0) | mds_e_q;
    md_haz   = mdD & md_busy;
    stall    = rs_haz | rt_haz | md_haz;
    IDEX_clr = stall;
  end

  // Next E entry and mult/div counter; a stalled or flushed D becomes one bubble
  always_comb begin
    bubble   = stall | flushE;
    md_go    = ~bubble & ((mdstartD == MD_MULT) | (mdstartD == MD_DIV));
    res_e_d  = bubble ? RES_NW : ResD;
    dst_e_d  = bubble ? 5'd0 : dstD;
    mds_e_d  = md_go;
    md_cnt_d = md_cnt_q;
    if (md_go && mdstartD == MD_MULT)     md_cnt_d = MULT_CYCLES;
    else if (md_go && mdstartD == MD_DIV) md_cnt_d = DIV_CYCLES;
    else if (md_cnt_q != 4'd0)            md_cnt_d = md_cnt_q - 4'd1;
  end

  // Scoreboard shift W<=M<=E<=D; reset clears everything including an in-flight divide
  always_ff @(posedge clk) begin
    if (reset) begin
      res_e_q  <= RES_NW;
      dst_e_q  <= 5'd0;
      mds_e_q  <= 1'b0;
      res_m_q  <= RES_NW;
      dst_m_q  <= 5'd0;
      res_w_q  <= RES_NW;
      dst_w_q  <= 5'd0;
      md_cnt_q <= 4'd0;
    end else begin
      res_w_q  <= res_m_q;
      dst_w_q  <= dst_m_q;
      res_m_q  <= res_e_q;
      dst_m_q  <= dst_e_q;
      res_e_q  <= res_e_d;
      dst_e_q  <= dst_e_d;
      mds_e_q  <= mds_e_d;
      md_cnt_q <= md_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Bench for hazard_stall_ctrl: directed scenarios plus randomized traffic against a pipeline model.
// Inputs change just after the rising edge; outputs are sampled on the falling edge.
// The model tracks pipeline contents as arrays and mult/div occupancy as a remaining-cycles count.
module tb_hazard_stall_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] rsD, rtD, dstD;
  logic [1:0] TuseRs, TuseRt, ResD, mdstartD;
  logic       mdD, flushE;
  logic       stall, IDEX_clr, md_busy;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // Model: index 0 = E, 1 = M, 2 = W
  int m_res [3];
  int m_dst [3];
  int m_busy_left;

  hazard_stall_ctrl dut (
    .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .TuseRs(TuseRs), .TuseRt(TuseRt),
    .ResD(ResD), .dstD(dstD), .mdD(mdD), .mdstartD(mdstartD), .flushE(flushE),
    .stall(stall), .IDEX_clr(IDEX_clr), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  // Cycles until the producer's value is ready, given how many stages it has advanced.
  function automatic int model_tnew(int res, int stage);
    int base;
    base = (res == 1) ? 1 : (res == 2) ? 2 : 0;
    return (base - stage > 0) ? base - stage : 0;
  endfunction

  function automatic bit model_src(int src, int tuse);
    bit h;
    h = 0;
    for (int s = 0; s < 3; s++)
      if (src != 0 && src == m_dst[s] && m_res[s] != 0 && model_tnew(m_res[s], s) > tuse) h = 1;
    return h;
  endfunction

  function automatic bit model_busy();
    return m_busy_left > 0;
  endfunction

  function automatic bit model_stall();
    return model_src(int'(rsD), int'(TuseRs)) || model_src(int'(rtD), int'(TuseRt)) ||
           (mdD && model_busy());
  endfunction

  task automatic model_edge(input bit st);
    if (reset) begin
      for (int s = 0; s < 3; s++) begin m_res[s] = 0; m_dst[s] = 0; end
      m_busy_left = 0;
    end else begin
      m_res[2] = m_res[1]; m_dst[2] = m_dst[1];
      m_res[1] = m_res[0]; m_dst[1] = m_dst[0];
      if (st || flushE) begin
        m_res[0] = 0; m_dst[0] = 0;
      end else begin
        m_res[0] = int'(ResD); m_dst[0] = int'(dstD);
      end
      if (!st && !flushE && mdstartD == 2'b01)      m_busy_left = 5;
      else if (!st && !flushE && mdstartD == 2'b10) m_busy_left = 10;
      else if (m_busy_left > 0)                     m_busy_left = m_busy_left - 1;
    end
  endtask

  // Advance one clock edge, keeping the model in step with the DUT.
  task automatic tick();
    bit st;
    st = model_stall();
    @(posedge clk);
    model_edge(st);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt, input logic [1:0] tus,
                       input logic [1:0] tut, input logic [1:0] res, input logic [4:0] dst,
                       input logic md, input logic [1:0] mds, input logic fl);
    rsD = rs; rtD = rt; TuseRs = tus; TuseRt = tut; ResD = res; dstD = dst;
    mdD = md; mdstartD = mds; flushE = fl;
  endtask

  task automatic nop();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic do_reset();
    nop();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b0) begin fail_cnt++; $display("FAIL reset_stall: got %b want 0", stall); end
    cmp_cnt++;
    if (IDEX_clr !== 1'b0) begin fail_cnt++; $display("FAIL reset_idex_clr: got %b want 0", IDEX_clr); end
    cmp_cnt++;
    if (md_busy !== 1'b0) begin fail_cnt++; $display("FAIL reset_md_busy: got %b want 0", md_busy); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 5'd8, 1'b0, 2'd0, 1'b0);  // lw $8
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b0) begin fail_cnt++; $display("FAIL load_use_issue: got %b want 0", stall); end
    tick();
    set_d(5'd8, 5'd0, 2'd1, 2'd3, 2'd1, 5'd9, 1'b0, 2'd0, 1'b0);  // addu uses $8, Tuse 1
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b1 || IDEX_clr !== 1'b1) begin
      fail_cnt++; $display("FAIL load_use_stall: got stall=%b clr=%b want 1/1", stall, IDEX_clr);
    end
    tick();
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b0) begin fail_cnt++; $display("FAIL load_use_release: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_load_branch();
    int n;
    do_reset();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 5'd8, 1'b0, 2'd0, 1'b0);  // lw $8
    tick();
    set_d(5'd0, 5'd8, 2'd3, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);  // beq on rt=$8, Tuse 0
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (stall === 1'b1) n++;
      tick();
    end
    cmp_cnt++;
    if (n != 2) begin fail_cnt++; $display("FAIL load_branch_cycles: got %0d want 2", n); end
  endtask

  task automatic test_zero_reg();
    do_reset();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd1, 5'd0, 1'b0, 2'd0, 1'b0);  // ALU writing $0
    tick();
    set_d(5'd0, 5'd0, 2'd0, 2'd0, 2'd1, 5'd3, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b0) begin fail_cnt++; $display("FAIL zero_reg: got %b want 0", stall); end
    tick();
    // Same-position ALU producer on a real register does hazard at Tuse 0
    set_d(5'd0, 5'd3, 2'd3, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b1) begin fail_cnt++; $display("FAIL alu_rt_tuse0: got %b want 1", stall); end
    tick();
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b0) begin fail_cnt++; $display("FAIL alu_rt_release: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_md();
    int n;
    int want;
    for (int op = 1; op <= 2; op++) begin
      want = (op == 1) ? 5 : 10;
      do_reset();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b1, op[1:0], 1'b0);  // mult/div
      @(negedge clk);
      cmp_cnt++;
      if (stall !== 1'b0 || md_busy !== 1'b0) begin
        fail_cnt++; $display("FAIL md_issue_%0d: got stall=%b busy=%b want 0/0", op, stall, md_busy);
      end
      tick();
      set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd1, 5'd10, 1'b1, 2'd0, 1'b0);   // mfhi $10
      n = 0;
      while (n < 30) begin
        @(negedge clk);
        if (stall !== 1'b1) break;
        n++;
        tick();
      end
      cmp_cnt++;
      if (n != want) begin fail_cnt++; $display("FAIL md_stall_len_%0d: got %0d want %0d", op, n, want); end
      cmp_cnt++;
      if (md_busy !== 1'b0) begin fail_cnt++; $display("FAIL md_busy_fall_%0d: got %b want 0", op, md_busy); end
      tick();
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 5'd8, 1'b0, 2'd0, 1'b1);  // flushed lw $8
    tick();
    set_d(5'd8, 5'd8, 2'd0, 2'd0, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0);
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b0) begin fail_cnt++; $display("FAIL flush_bubble: got %b want 0", stall); end
    tick();
    // Flush and hazard together: stall holds D, E gets one bubble
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 5'd8, 1'b0, 2'd0, 1'b0);
    tick();
    set_d(5'd8, 5'd0, 2'd1, 2'd3, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1);
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b1) begin fail_cnt++; $display("FAIL flush_hazard_stall: got %b want 1", stall); end
    tick();
    flushE = 1'b0;
    @(negedge clk);
    cmp_cnt++;
    if (stall !== 1'b0) begin fail_cnt++; $display("FAIL flush_hazard_release: got %b want 0", stall); end
    tick();
  endtask

  task automatic test_reset_mid_div();
    do_reset();
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd0, 5'd0, 1'b1, 2'd2, 1'b0);  // div
    tick();
    nop();
    for (int i = 0; i < 4; i++) tick();                            // count now 6
    @(negedge clk);
    cmp_cnt++;
    if (md_busy !== 1'b1) begin fail_cnt++; $display("FAIL mid_div_busy: got %b want 1", md_busy); end
    set_d(5'd0, 5'd0, 2'd3, 2'd3, 2'd2, 5'd5, 1'b1, 2'd1, 1'b1);  // lw $5 + mult + flush, all overridden
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_d(5'd5, 5'd5, 2'd0, 2'd0, 2'd1, 5'd6, 1'b1, 2'd0, 1'b0);
    @(negedge clk);
    cmp_cnt++;
    if (md_busy !== 1'b0 || stall !== 1'b0 || IDEX_clr !== 1'b0) begin
      fail_cnt++;
      $display("FAIL reset_abort_div: got busy=%b stall=%b clr=%b want 0/0/0", md_busy, stall, IDEX_clr);
    end
    tick();
  endtask

  task automatic test_random();
    bit es, eb;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 3) == 0),
            $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
      reset = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      es = model_stall();
      eb = model_busy();
      cmp_cnt++;
      if (stall !== es || IDEX_clr !== es || md_busy !== eb) begin
        fail_cnt++;
        $display("FAIL random_%0d: got stall=%b clr=%b busy=%b want %b/%b/%b",
                 i, stall, IDEX_clr, md_busy, es, es, eb);
      end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    nop();
    for (int s = 0; s < 3; s++) begin m_res[s] = 0; m_dst[s] = 0; end
    m_busy_left = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_load_use();
    test_load_branch();
    test_zero_reg();
    test_md();
    test_flush();
    test_reset_mid_div();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-002 SHALL have port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port `rsD`, input, 5 bits: D-stage rs number.
REQ-004 SHALL have port `rtD`, input, 5 bits: D-stage rt number.
REQ-005 SHALL have port `TuseRs`, input, 2 bits: cycles until the D instruction needs rs; 3 = not used.
REQ-006 SHALL have port `TuseRt`, input, 2 bits: cycles until the D instruction needs rt; 3 = not used.
REQ-007 SHALL have port `ResD`, input, 2 bits: D result class: 00 ResNW, 01 ResALU, 10 ResDM, 11 ResPC.
REQ-008 SHALL have port `dstD`, input, 5 bits: D destination register.
REQ-009 SHALL have port `mdD`, input, 1 bit: D instruction accesses HI/LO (mult, div, mfhi, mflo, mthi, mtlo).
REQ-010 SHALL have port `mdstartD`, input, 2 bits: 00 none, 01 mult, 10 div.
REQ-011 SHALL have port `flushE`, input, 1 bit: exception/eret flush of the D-to-E transfer (drives IDEX_clr2 of the ID/EX register).
REQ-012 SHALL have port `stall`, output, 1 bit: hold PC and IF/ID.
REQ-013 SHALL have port `IDEX_clr`, output, 1 bit: insert a bubble into ID/EX; equals `stall`.
REQ-014 SHALL have port `md_busy`, output, 1 bit: multiply/divide unit occupied.

Function
REQ-015 SHALL keep a scoreboard of three entries {Res, dst} for E, M and W, mirroring the ID/EX, EX/MEM and MEM/WB contents.
REQ-016 On each clock the scoreboard SHALL shift: W<=M, then M<=E, then E<=D; E SHALL instead load {ResNW, 0} when `stall` or `flushE` is 1.
REQ-017 Tnew SHALL be: ALU entry 1 in E, 0 in M/W; DM entry 2 in E, 1 in M, 0 in W; PC entry 0 everywhere; ResNW entries are never a hazard.
REQ-018 A source hazard SHALL exist for stage X when src != 0, src == dst(X), Res(X) != ResNW and Tnew(X) > Tuse(src); Tuse = 3 never hazards.
REQ-019 `stall` SHALL be the combinational OR of the rs hazards, the rt hazards and the md hazard (REQ-022), all over E/M/W.
REQ-020 The md counter SHALL load 5 on an unstalled, unflushed mult and 10 on such a div, then decrement by 1 per cycle to 0; it SHALL not wrap below 0.
REQ-021 `md_busy` SHALL be 1 while the counter is nonzero, or while E holds an md start not yet counted (the start cycle).
REQ-022 An md hazard SHALL exist when `mdD` = 1 and `md_busy` = 1.
REQ-023 `mdstartD` SHALL be ignored while `stall` or `flushE` = 1 (no counter load).
REQ-024 When `flushE` and a hazard occur in the same cycle, the E bubble SHALL be inserted once; `stall` SHALL still hold PC/IF/ID.
REQ-025 There SHALL be no latency from the inputs to `stall`; scoreboard effects SHALL appear one cycle after the edge.

Reset
REQ-026 On `reset` = 1 at a clock edge, all scoreboard entries SHALL become {ResNW, 0} and the md counter SHALL become 0.
REQ-027 After that reset edge, `stall` = 0, `IDEX_clr` = 0 and `md_busy` = 0 until new hazards arrive.
REQ-028 `reset` SHALL override a simultaneous `flushE` or md start.
REQ-029 A reset mid-divide SHALL abort the count immediately.

Verification
REQ-030 Load-use: lw with ResDM, dst 8; next cycle rsD = 8, TuseRs = 1 -> stall = 1 for exactly 1 cycle, then 0 with the entry in M (Tnew 1).
REQ-031 lw dst 8 followed by beq with rsD = 8, TuseRs = 0 -> stall = 2 cycles.
REQ-032 ALU dst 0 followed by rsD = 0, TuseRs = 0 -> stall = 0 (register $0 never hazards).
REQ-033 div issued, next cycle mfhi (mdD = 1) -> stall stays 1 until the counter reaches 0 (10 cycles), then 0; md_busy falls on the same cycle.
REQ-034 flushE = 1 with lw in D -> E becomes a bubble, and a following rsD = dst sees no hazard from it.
REQ-035 reset asserted during a div with count 6 -> next cycle md_busy = 0, stall = 0, and all entries are ResNW.
